// File: rtl/negate_arbiter.sv
// rtl/negate_arbiter.sv - round-robin arbiter sequencing a shared slow two's-complement negation unit
module negate_arbiter #(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] neg_in,
  input  logic [WIDTH-1:0] neg_out,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [7:0]       CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] neg_in_q, neg_in_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             last_q, last_d;
  logic             pick1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_in_d = neg_in_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    last_d   = last_q;
    // last_q=1 means requester 1 was served last, so requester 0 wins a tie
    pick1    = req1 && (!req0 || !last_q);
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          neg_in_d = pick1 ? op1 : op0;
          gnt0_d   = !pick1;
          gnt1_d   = pick1;
          last_d   = pick1;
          cnt_d    = CNT_INIT;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          result_d = neg_out;
          ovf_d    = (neg_in_q == MIN_VAL);
          done0_d  = gnt0_q;
          done1_d  = gnt1_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      neg_in_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_in_q <= neg_in_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      last_q   <= last_d;
    end
  end

  assign neg_in = neg_in_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;

endmodule

// File: tb/tb_negate_arbiter.sv
// tb/tb_negate_arbiter.sv - scoreboard bench for negate_arbiter with a slow-settling negation model
module tb_negate_arbiter;

  localparam int W = 64;
  localparam int S = 4;
  localparam logic [63:0] MIN_VAL = 64'h8000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          run = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  op0, op1;
  logic [W-1:0]  neg_in, neg_out, result;
  logic          gnt0, gnt1, done0, done1, ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        who;
    logic [63:0] res;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];

  negate_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .req1(req1), .op1(op1),
    .neg_in(neg_in), .neg_out(neg_out),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .ovf(ovf)
  );

  always #5 if (run) clk = ~clk;

  // Negation unit: output is garbage until neg_in has been stable for S-1 edges
  int          stable  = 0;
  logic [63:0] prev_in = '0;
  always @(posedge clk) begin
    if (neg_in != prev_in) stable <= 1;
    else if (stable < 1000) stable <= stable + 1;
    prev_in <= neg_in;
  end
  assign neg_out = (stable >= S - 1) ? (~neg_in + 64'd1) : 64'hDEAD_BEEF_0BAD_F00D;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic who, input logic [63:0] op);
    exp_t e;
    e.who = who;
    e.res = ~op + 64'd1;
    e.ovf = (op == MIN_VAL);
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 64'({gnt0, gnt1, done0, done1, ovf}), 64'd0);
    chk({tag, "_neg_in"}, neg_in, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      chk("done_excl", 64'(done0 && done1), 64'd0);
      chk("gnt_excl", 64'(gnt0 && gnt1), 64'd0);
      if (done0 || done1) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 64'(done0 | done1), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("who", 64'(done1), 64'(e.who));
          chk("result", result, e.res);
          chk("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
  end

  task automatic wait_done(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      seen = done0 || done1;
    end
    if (!seen) chk("timeout", 64'(seen), 64'd1);
  endtask

  task automatic xact(input logic who, input logic [63:0] op, output int lat);
    int l2;
    @(negedge clk);
    if (who) begin req1 = 1'b1; op1 = op; end
    else     begin req0 = 1'b1; op0 = op; end
    sbq.push_back(model(who, op));
    @(posedge clk);
    @(negedge clk);
    chk("gnt_on", 64'({gnt1, gnt0}), who ? 64'd2 : 64'd1);
    wait_done(l2);
    lat  = l2 + 1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("gnt_off", 64'({gnt1, gnt0, done1, done0}), 64'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    #3 chk_zero("por");
    run = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero("idle");

    xact(1'b0, 64'd5, lat);
    chk("lat_single", 64'(lat), 64'(S + 1));
    chk("res_5", result, 64'hFFFF_FFFF_FFFF_FFFB);

    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; op0 = 64'd1; op1 = 64'd2;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(model(1'b0, 64'd1));
      sbq.push_back(model(1'b1, 64'd2));
    end
    @(negedge clk);
    reset = 1'b0;
    wait_done(lat);
    chk("lat_rr_first", 64'(lat), 64'(S + 1));
    chk("res_m1", result, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      wait_done(lat);
      chk("lat_rr", 64'(lat), 64'(S + 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    xact(1'b1, MIN_VAL, lat);
    chk("res_min", result, MIN_VAL);
    chk("ovf_min", 64'(ovf), 64'd1);
    xact(1'b1, 64'd0, lat);
    chk("res_zero", result, 64'd0);
    chk("ovf_zero", 64'(ovf), 64'd0);

    @(negedge clk);
    req0 = 1'b1; op0 = 64'd7;
    sbq.push_back(model(1'b0, 64'd7));
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    op0 = 64'd9; req0 = 1'b0;
    wait_done(lat);
    chk("lat_mid", 64'(lat + 2), 64'(S + 1));
    chk("res_m7", result, 64'hFFFF_FFFF_FFFF_FFF9);
    @(negedge clk);

    @(negedge clk);
    req0 = 1'b1; op0 = 64'd3;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back(model(1'b0, 64'd3));
    wait_done(lat);
    chk("lat_rerun", 64'(lat), 64'(S + 1));
    req0 = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end

endmodule
